// File: rtl/z80_screen_snoop.sv
// Purpose: snoop Z80 memory writes into the ZX screen window and queue them as {offset, data} beats.
// Latency: SYNC_STAGES+FILTER_CYCLES+1 CLK edges from stable bus pins to the entry at the FIFO head.
// Backpressure: a FIFO_DEPTH-entry queue absorbs a stalled wr_ready; writes arriving while it is full are dropped and flag overflow.
// Optional: define SNOOP_ACTIVITY_LED_EN to stretch every accepted push onto LED1 for 2^20 cycles.
module z80_screen_snoop #(
  parameter int          SYNC_STAGES   = 2,
  parameter int          FILTER_CYCLES = 2,
  parameter int          FIFO_DEPTH    = 8,
  parameter logic [15:0] BASE_ADDR     = 16'h4000,
  parameter int          WINDOW_SIZE   = 6912
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [15:0]                   A,
  input  logic [7:0]                    D,
  input  logic                          MRQ,
  input  logic                          WR,
  output logic [12:0]                   wr_addr,
  output logic [7:0]                    wr_data,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  input  logic                          clear_overflow,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          LED1
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [16:0]      WIN_END = 17'(BASE_ADDR) + 17'(WINDOW_SIZE);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_QUAL, S_HOLD} state_t;

  // ---------------- bus synchronisers ----------------
  logic [SYNC_STAGES-1:0][15:0] a_sync;
  logic [SYNC_STAGES-1:0][7:0]  d_sync;
  logic [SYNC_STAGES-1:0]       mrq_sync;
  logic [SYNC_STAGES-1:0]       wr_sync;

  // Strobe chains reset to the deasserted level so leaving reset never looks like a bus write
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_sync   <= '0;
      d_sync   <= '0;
      mrq_sync <= '1;
      wr_sync  <= '1;
    end else begin
      a_sync   <= {a_sync[SYNC_STAGES-2:0], A};
      d_sync   <= {d_sync[SYNC_STAGES-2:0], D};
      mrq_sync <= {mrq_sync[SYNC_STAGES-2:0], MRQ};
      wr_sync  <= {wr_sync[SYNC_STAGES-2:0], WR};
    end
  end

  logic [15:0] a_s;
  logic [7:0]  d_s;
  logic        strobe_s;
  assign a_s      = a_sync[SYNC_STAGES-1];
  assign d_s      = d_sync[SYNC_STAGES-1];
  assign strobe_s = !mrq_sync[SYNC_STAGES-1] && !wr_sync[SYNC_STAGES-1];

  // ---------------- write qualifier FSM ----------------
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             push_vld;
  entry_t           push_dat;
  logic             capture;
  logic             in_win;
  logic [12:0]      a_off;

  // Capture fires on the edge where the strobe has been low for FILTER_CYCLES consecutive cycles
  always_comb begin
    capture = 1'b0;
    if (strobe_s) begin
      if (state == S_IDLE && FILTER_CYCLES == 1)
        capture = 1'b1;
      else if (state == S_QUAL && cnt == CNT_W'(FILTER_CYCLES - 1))
        capture = 1'b1;
    end
  end

  // Modulo-2^13 subtraction equals the truncated full-width offset
  assign in_win = (a_s >= BASE_ADDR) && ({1'b0, a_s} < WIN_END);
  assign a_off  = a_s[12:0] - BASE_ADDR[12:0];

  // Qualify the strobe, latch address/data on capture, then hold until the strobe ends
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      push_vld <= 1'b0;
      push_dat <= '0;
    end else begin
      push_vld <= capture && in_win;
      if (capture)
        push_dat <= '{addr: a_off, data: d_s};
      case (state)
        S_IDLE: begin
          if (strobe_s) begin
            cnt   <= CNT_W'(1);
            state <= capture ? S_HOLD : S_QUAL;
          end
        end
        S_QUAL: begin
          if (!strobe_s) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (capture)
              state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!strobe_s) begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------- first-word-fall-through write queue ----------------
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] level;
  entry_t           head_q;

  logic             pop;
  logic             push_acc;
  logic             drop;
  logic [LVL_W-1:0] level_nxt;
  logic [LVL_W-1:0] remain;
  logic [PTR_W-1:0] rd_ptr_nxt;
  entry_t           head_nxt;

  // A full queue still accepts a push when the head leaves on the same edge
  always_comb begin
    pop        = wr_valid && wr_ready;
    push_acc   = push_vld && ((level != LVL_FULL) || pop);
    drop       = push_vld && (level == LVL_FULL) && !pop;
    level_nxt  = level + LVL_W'(push_acc) - LVL_W'(pop);
    remain     = level - LVL_W'(pop);
    rd_ptr_nxt = rd_ptr + PTR_W'(pop);
    head_nxt   = (remain == '0) ? push_dat : mem[rd_ptr_nxt];
  end

  // Storage array needs no reset: entries are only read after being written
  always_ff @(posedge CLK) begin
    if (push_acc)
      mem[wr_ptr] <= push_dat;
  end

  // Pointers, occupancy, registered head and sticky overflow
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      wr_valid <= 1'b0;
      head_q   <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr_nxt;
      level    <= level_nxt;
      wr_valid <= (level_nxt != '0);
      if (push_acc)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (level_nxt != '0)
        head_q <= head_nxt;
      if (drop)
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
    end
  end

  assign wr_addr    = head_q.addr;
  assign wr_data    = head_q.data;
  assign fifo_level = level;

  // ---------------- activity LED ----------------
`ifdef SNOOP_ACTIVITY_LED_EN
  logic [20:0] led_cnt;

  // Reload the stretch counter on every accepted push, then count down to zero
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      led_cnt <= '0;
    else if (push_acc)
      led_cnt <= 21'h10_0000;
    else if (led_cnt != '0)
      led_cnt <= led_cnt - 21'd1;
  end

  assign LED1 = (led_cnt != '0);
`else
  assign LED1 = 1'b0;
`endif

endmodule

// File: tb/tb_z80_screen_snoop.sv
// Purpose: directed vector bench for z80_screen_snoop (window filter, glitch reject, queueing, overflow, reset).
// Latency: checks the 5-edge pin-to-head latency with default parameters.
// Backpressure: drives wr_ready low to fill the queue and pulses it to exercise pop/push collisions.
module tb_z80_screen_snoop;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] A;
  logic [7:0]  D;
  logic        MRQ;
  logic        WR;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        clear_overflow;
  logic        overflow;
  logic [3:0]  fifo_level;
  logic        LED1;

  int n_cmp  = 0;
  int n_fail = 0;

  z80_screen_snoop dut (
    .CLK            (CLK),
    .RST            (RST),
    .A              (A),
    .D              (D),
    .MRQ            (MRQ),
    .WR             (WR),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .clear_overflow (clear_overflow),
    .overflow       (overflow),
    .fifo_level     (fifo_level),
    .LED1           (LED1)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    bit          push;
    logic [12:0] addr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus write: strobes low for low_cyc cycles, then idle long enough for the FSM to return to IDLE
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int low_cyc);
    @(negedge CLK);
    A = a; D = d; MRQ = 1'b0; WR = 1'b0;
    repeat (low_cyc) @(negedge CLK);
    MRQ = 1'b1; WR = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic pop_one();
    @(negedge CLK);
    wr_ready = 1'b1;
    @(negedge CLK);
    wr_ready = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{a: 16'h4000, d: 8'hA5, push: 1'b1, addr: 13'h0000};
    vecs[1] = '{a: 16'h3FFF, d: 8'h11, push: 1'b0, addr: 13'h0000};
    vecs[2] = '{a: 16'h5B00, d: 8'h22, push: 1'b0, addr: 13'h0000};
    vecs[3] = '{a: 16'h5AFF, d: 8'h33, push: 1'b1, addr: 13'h1AFF};
    vecs[4] = '{a: 16'h5800, d: 8'h47, push: 1'b1, addr: 13'h1800};
    vecs[5] = '{a: 16'h4001, d: 8'h5A, push: 1'b1, addr: 13'h0001};
    vecs[6] = '{a: 16'h0000, d: 8'h66, push: 1'b0, addr: 13'h0000};
    vecs[7] = '{a: 16'hFFFF, d: 8'h77, push: 1'b0, addr: 13'h0000};

    RST = 1'b0; A = '0; D = '0; MRQ = 1'b1; WR = 1'b1;
    wr_ready = 1'b0; clear_overflow = 1'b0;
    #1;
    check("rst_valid", wr_valid, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_led", LED1, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);

    // Latency: strobe drive lands just after a negedge, head appears after the 5th posedge
    wr_ready = 1'b1;
    A = 16'h4000; D = 8'hA5; MRQ = 1'b0; WR = 1'b0;
    repeat (4) @(posedge CLK);
    #1 check("lat_valid_e4", wr_valid, 0);
    @(posedge CLK);
    #1 check("lat_valid_e5", wr_valid, 1);
    check("lat_addr", wr_addr, 13'h0000);
    check("lat_data", wr_data, 8'hA5);
    check("lat_level_e5", fifo_level, 1);
    @(posedge CLK);
    #1 check("lat_level_e6", fifo_level, 0);
    check("lat_valid_e6", wr_valid, 0);
    @(negedge CLK);
    MRQ = 1'b1; WR = 1'b1;
    wr_ready = 1'b0;
    repeat (8) @(negedge CLK);
    check("lat_single_beat", fifo_level, 0);

    // Window filter table
    for (int i = 0; i < 8; i++) begin
      bus_write(vecs[i].a, vecs[i].d, 4);
      check($sformatf("vec%0d_level", i), fifo_level, vecs[i].push ? 1 : 0);
      check($sformatf("vec%0d_ovf", i), overflow, 0);
      if (vecs[i].push) begin
        check($sformatf("vec%0d_addr", i), wr_addr, vecs[i].addr);
        check($sformatf("vec%0d_data", i), wr_data, vecs[i].d);
        pop_one();
        check($sformatf("vec%0d_drained", i), fifo_level, 0);
      end
    end

    // Glitch of one cycle is rejected, long strobe yields one entry
    @(negedge CLK);
    A = 16'h4123; D = 8'hEE; MRQ = 1'b0; WR = 1'b0;
    @(negedge CLK);
    MRQ = 1'b1; WR = 1'b1;
    repeat (8) @(negedge CLK);
    check("glitch_level", fifo_level, 0);
    bus_write(16'h5800, 8'h47, 40);
    check("long_level", fifo_level, 1);
    check("long_addr", wr_addr, 13'h1800);
    check("long_data", wr_data, 8'h47);
    pop_one();
    check("long_drained", fifo_level, 0);

    // Overflow: nine writes into an eight-entry queue
    for (int i = 0; i < 9; i++)
      bus_write(16'h4000 + 16'(i), 8'(8'hC0 + i), 4);
    check("ovf_level", fifo_level, 8);
    check("ovf_flag", overflow, 1);
    @(negedge CLK);
    wr_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check($sformatf("ovf_pop%0d_addr", j), wr_addr, 13'(j));
      check($sformatf("ovf_pop%0d_data", j), wr_data, 8'(8'hC0 + j));
      @(negedge CLK);
    end
    wr_ready = 1'b0;
    check("ovf_drain_level", fifo_level, 0);
    check("ovf_drain_valid", wr_valid, 0);
    check("ovf_sticky", overflow, 1);
    clear_overflow = 1'b1;
    @(negedge CLK);
    clear_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Full queue with a pop landing on the same edge as a new push
    for (int i = 0; i < 8; i++)
      bus_write(16'h4010 + 16'(i), 8'(8'h10 + i), 4);
    check("coll_full", fifo_level, 8);
    @(negedge CLK);
    A = 16'h4100; D = 8'hEE; MRQ = 1'b0; WR = 1'b0;
    repeat (4) @(negedge CLK);
    wr_ready = 1'b1;
    @(negedge CLK);
    wr_ready = 1'b0;
    check("coll_level", fifo_level, 8);
    check("coll_ovf", overflow, 0);
    check("coll_head", wr_addr, 13'h0011);
    repeat (2) @(negedge CLK);
    MRQ = 1'b1; WR = 1'b1;
    repeat (5) @(negedge CLK);
    check("coll_level_after", fifo_level, 8);
    check("coll_ovf_after", overflow, 0);
    wr_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check($sformatf("coll_pop%0d_addr", j), wr_addr, (j < 7) ? 13'(13'h11 + j) : 13'h0100);
      check($sformatf("coll_pop%0d_data", j), wr_data, (j < 7) ? 8'(8'h11 + j) : 8'hEE);
      @(negedge CLK);
    end
    wr_ready = 1'b0;
    check("coll_drained", fifo_level, 0);

    // Reset while three entries are queued and a write is mid-qualification
    for (int i = 0; i < 3; i++)
      bus_write(16'h4020 + 16'(i), 8'(8'h60 + i), 4);
    check("rst2_pre_level", fifo_level, 3);
    @(negedge CLK);
    A = 16'h4030; D = 8'h77; MRQ = 1'b0; WR = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    check("rst2_valid", wr_valid, 0);
    check("rst2_level", fifo_level, 0);
    check("rst2_addr", wr_addr, 0);
    check("rst2_data", wr_data, 0);
    MRQ = 1'b1; WR = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    check("rst2_no_stale", fifo_level, 0);
    check("rst2_no_stale_valid", wr_valid, 0);
    bus_write(16'h4040, 8'h99, 4);
    check("rst2_next_level", fifo_level, 1);
    check("rst2_next_addr", wr_addr, 13'h0040);
    check("rst2_next_data", wr_data, 8'h99);
    pop_one();
    check("rst2_next_drained", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_screen_snoop.md
Name: z80_screen_snoop

Overview:
- Upstream stage of the VGA screen renderer.
- Passively watches the asynchronous Z80 bus, qualifies memory write cycles, and filters them to the ZX screen window 0x4000–0x5AFF.
- Queues each qualified write in a FIFO and presents it as a 13-bit offset plus data on a valid/ready write port.
- The renderer's screen memory consumes that port.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on A, D, MRQ, WR (minimum 2).
- FILTER_CYCLES, 2, consecutive CLK cycles MRQ and WR must both be low before a write is accepted (minimum 1).
- FIFO_DEPTH, 8, write queue entries (power of two, minimum 2).
- BASE_ADDR, 16'h4000, first snooped Z80 address.
- WINDOW_SIZE, 6912, number of snooped bytes (bitmap 6144 + attributes 768).

Ports:
- CLK  in  1  system/pixel-domain clock; all logic on posedge.
- RST  in  1  asynchronous, active-low reset.
- A  in  16  Z80 address bus (asynchronous).
- D  in  8  Z80 data bus (asynchronous).
- MRQ  in  1  Z80 MREQ, active low (asynchronous).
- WR  in  1  Z80 WR, active low (asynchronous).
- wr_addr  out  13  offset (A − BASE_ADDR) of the head FIFO entry.
- wr_data  out  8  data of the head FIFO entry.
- wr_valid  out  1  head entry present.
- wr_ready  in  1  consumer accepts head entry when wr_valid & wr_ready.
- clear_overflow  in  1  synchronous clear of overflow.
- overflow  out  1  sticky; a write was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- LED1  out  1  activity indicator (see Optional Feature).

Behaviour:
- Reset (RST=0, async):
  - Synchronisers, FSM, filter counter, FIFO pointers and overflow all clear.
  - wr_valid=0, wr_addr=0, wr_data=0, fifo_level=0, LED1=0.
- Synchronisation: A, D, MRQ and WR each pass through SYNC_STAGES flops. Only synchronised copies are used downstream.
- FSM states:
  - IDLE: when synced MRQ=0 and WR=0, load counter=1. If FILTER_CYCLES==1, go to CAPTURE behaviour immediately; otherwise go to QUAL.
  - QUAL: while both signals stay low, counter increments. When counter reaches FILTER_CYCLES, do CAPTURE on that edge. If either signal goes high first, return to IDLE, clear the counter, and record nothing (glitch rejected).
  - CAPTURE (same edge as qualification): latch synced A and D, then go to HOLD.
    - Push condition: BASE_ADDR ≤ A < BASE_ADDR+WINDOW_SIZE.
    - Pushed entry is {A−BASE_ADDR truncated to 13 bits, D}.
    - An out-of-window write is discarded silently and does not set overflow.
  - HOLD: wait until synced MRQ=1 or WR=1, then go to IDLE. This guarantees exactly one push per bus write, however long the strobe lasts.
- Latency: pins stable → entry at FIFO head with wr_valid=1 takes SYNC_STAGES+FILTER_CYCLES+1 CLK edges when the FIFO is empty (5 with defaults).
- FIFO:
  - First-word-fall-through with registered outputs. wr_addr/wr_data are valid whenever wr_valid=1 and hold their last value when empty.
  - Pop on wr_valid & wr_ready. Push and pop on the same edge are both honoured, so level is unchanged.
  - Full and push without pop: the entry is dropped, FIFO contents are unchanged, and overflow is set.
  - Full with simultaneous pop and push: both succeed and no overflow is raised.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.
- overflow: sticky. clear_overflow=1 clears it on the next edge; a new overflow on that same edge wins (stays 1).
- wr_ready is ignored while wr_valid=0.

Optional Feature:
- Macro SNOOP_ACTIVITY_LED_EN.
- Defined: LED1 goes high for 2^20 CLK cycles after every accepted in-window push. The counter reloads on each new push. Reset value is 0.
- Undefined: LED1 is constant 0 and the stretch counter is not built.

Test Plan:
- Z80 write A=0x4000, D=0xA5, MRQ/WR low 6 CLKs, wr_ready=1 → one beat, wr_addr=0x0000, wr_data=0xA5, wr_valid rises on edge 5 after strobes; fifo_level back to 0.
- Writes to 0x3FFF, 0x5B00 and 0x5AFF → only 0x5AFF emitted (wr_addr=0x1AFF); overflow=0.
- MRQ/WR low for 1 CLK only (glitch), then a 40-CLK-long strobe at 0x5800, D=0x47 → glitch ignored; exactly one entry {0x1800, 0x47}.
- wr_ready=0, 9 writes to 0x4000..0x4008 → fifo_level=8, overflow=1, 9th write lost. Then wr_ready=1 → entries 0x0000..0x0007 popped in order. Pulse clear_overflow → overflow=0.
- FIFO full, then pulse wr_ready coincident with a new push of 0x4100 → no overflow, level stays 8, 0x0100 emitted last.
- Assert RST mid-QUAL and with 3 entries queued → outputs zero immediately. After release, no stale entry appears and the next write is emitted normally.
